// File: rtl/mem_wb_stage_if.sv
// Execute-bundle input, data-memory bus and register-file write port for mem_wb_stage.
// master: execute stage + memory + register file side; slave: the stage itself.
interface mem_wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] exe_out;
  logic [31:0] store_data;
  logic [3:0]  rd;
  logic        is_load;
  logic        is_store;
  logic        needs_wb;
  logic [31:0] pc_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;
  logic [31:0] pc_out;
  logic        mem_err;

  modport master (
    output in_valid, exe_out, store_data, rd, is_load, is_store, needs_wb, pc_in,
    output mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  rf_we, rf_waddr, rf_wdata, retire, pc_out, mem_err
  );

  modport slave (
    input  in_valid, exe_out, store_data, rd, is_load, is_store, needs_wb, pc_in,
    input  mem_rdata, mem_ack,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output rf_we, rf_waddr, rf_wdata, retire, pc_out, mem_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: at most one req/ack memory transaction per
// instruction, then a single-cycle register-file write and retire pulse.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic            clk,
  input logic            rst,
  mem_wb_stage_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StMem, StWb} state_e;

  // Last MEM cycle index (counter value) before the request is abandoned.
  localparam logic [7:0] CntLimit = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] exe_q, exe_d;
  logic [31:0] sdata_q, sdata_d;
  logic [3:0]  rd_q, rd_d;
  logic        is_load_q, is_load_d;
  logic        is_store_q, is_store_d;
  logic        needs_wb_q, needs_wb_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        rf_we_q, rf_we_d;
  logic [3:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        retire_q, retire_d;
  logic [31:0] pc_out_q, pc_out_d;

  // Write-back source for the instruction leaving this cycle.
  logic        to_wb;
  logic        suppress;
  logic [3:0]  wb_rd;
  logic        wb_store;
  logic        wb_needs;
  logic [31:0] wb_pc;
  logic [31:0] wb_data;

  logic        mem_op;
  logic        in_mem;

  assign mem_op       = bus.is_load | bus.is_store;
  assign in_mem       = (state_q == StMem);
  assign bus.in_ready = (state_q == StIdle) && !rst;
  assign bus.mem_req  = in_mem;
  assign bus.mem_we   = in_mem && is_store_q;
  assign bus.mem_addr = in_mem ? exe_q : 32'h0;
  assign bus.mem_wdata = (in_mem && is_store_q) ? sdata_q : 32'h0;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.retire   = retire_q;
  assign bus.pc_out   = pc_out_q;
  assign bus.mem_err  = err_q;

  // Next-state, bundle latching, timeout counting and write-back selection.
  always_comb begin
    state_d    = state_q;
    exe_d      = exe_q;
    sdata_d    = sdata_q;
    rd_d       = rd_q;
    is_load_d  = is_load_q;
    is_store_d = is_store_q;
    needs_wb_d = needs_wb_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    to_wb      = 1'b0;
    suppress   = 1'b0;
    wb_rd      = rd_q;
    wb_store   = is_store_q;
    wb_needs   = needs_wb_q;
    wb_pc      = pc_q;
    wb_data    = exe_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && bus.in_ready) begin
          exe_d      = bus.exe_out;
          sdata_d    = bus.store_data;
          rd_d       = bus.rd;
          is_load_d  = bus.is_load;
          is_store_d = bus.is_store;
          needs_wb_d = bus.needs_wb;
          pc_d       = bus.pc_in;
          // Retirement straight from IDLE uses the incoming bundle directly.
          wb_rd      = bus.rd;
          wb_store   = bus.is_store;
          wb_needs   = bus.needs_wb;
          wb_pc      = bus.pc_in;
          wb_data    = bus.exe_out;
          if (mem_op && (bus.exe_out[1:0] != 2'b00)) begin
            err_d    = 1'b1;
            suppress = 1'b1;
            to_wb    = 1'b1;
          end else if (mem_op) begin
            state_d = StMem;
            cnt_d   = 8'd0;
          end else begin
            to_wb = 1'b1;
          end
        end
      end
      StMem: begin
        // Ack wins over a simultaneous timeout.
        if (bus.mem_ack) begin
          to_wb = 1'b1;
          if (is_load_q && !is_store_q) begin
            wb_data = bus.mem_rdata;
          end
        end else if (cnt_q == CntLimit) begin
          to_wb    = 1'b1;
          suppress = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (to_wb) begin
      state_d = StWb;
    end

    rf_we_d    = to_wb && wb_needs && !wb_store && !suppress && (wb_rd != 4'd0);
    rf_waddr_d = to_wb ? wb_rd : 4'd0;
    rf_wdata_d = to_wb ? wb_data : 32'h0;
    retire_d   = to_wb;
    pc_out_d   = to_wb ? wb_pc : 32'h0;
  end

  // State, latched bundle and registered write-back outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      exe_q      <= 32'h0;
      sdata_q    <= 32'h0;
      rd_q       <= 4'd0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      needs_wb_q <= 1'b0;
      pc_q       <= 32'h0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 4'd0;
      rf_wdata_q <= 32'h0;
      retire_q   <= 1'b0;
      pc_out_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      exe_q      <= exe_d;
      sdata_q    <= sdata_d;
      rd_q       <= rd_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      needs_wb_q <= needs_wb_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retire_q   <= retire_d;
      pc_out_q   <= pc_out_d;
    end
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage that consumes the execute stage's result bundle (ALU result/address, store data, destination register, load/store/write-back flags, PC). It performs at most one data-memory transaction per instruction over a req/ack bus, then issues a single-cycle register-file write. It back-pressures the execute stage through a valid/ready handshake while a transaction is outstanding.

## Interface
- TIMEOUT_CYCLES, 16: max cycles mem_req may stay high without mem_ack before aborting (range 2..255)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute bundle valid this cycle
- in_ready  out  1  stage accepts a bundle this cycle (combinational: state==IDLE && !rst)
- exe_out  in  32  ALU result; byte address for load/store
- store_data  in  32  RS2 value written by stores
- rd  in  4  destination register index
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store
- needs_wb  in  1  instruction writes the register file
- pc_in  in  32  PC of the instruction
- mem_req  out  1  memory request, held until ack or abort
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  32  word-aligned address; valid while mem_req
- mem_wdata  out  32  write data; valid while mem_req && mem_we
- mem_rdata  in  32  read data, sampled only in the mem_ack cycle
- mem_ack  in  1  one-cycle transaction completion
- rf_we  out  1  register-file write strobe, one cycle
- rf_waddr  out  4  register index for rf_we
- rf_wdata  out  32  write data for rf_we
- retire  out  1  one-cycle pulse when an instruction leaves the stage
- pc_out  out  32  PC of the retiring instruction, valid with retire
- mem_err  out  1  sticky error (misaligned access or timeout), cleared only by rst

## Operation
- States: IDLE, MEM, WB. Reset -> IDLE; all registered outputs 0, mem_err 0, timeout counter 0.
- IDLE: on in_valid && in_ready, latch the bundle. If is_load or is_store: if exe_out[1:0]!=0, set mem_err and go to WB with write suppressed, with no request issued. Otherwise go to MEM. If neither flag is set, go to WB. is_load && is_store together is treated as a store.
- MEM: mem_req=1, mem_addr=latched exe_out, mem_we=latched is_store, mem_wdata=latched store_data. On mem_ack: capture mem_rdata for loads; drop mem_req; go to WB. If the counter reaches TIMEOUT_CYCLES without ack: drop mem_req, set mem_err, suppress the write, go to WB.
- WB (one cycle): rf_we = latched needs_wb && !is_store && !suppressed && rd!=0. rf_waddr=rd. rf_wdata = loaded data for loads, otherwise latched exe_out. retire=1 and pc_out=latched pc_in regardless of suppression. Next state is IDLE.
- mem_ack outside MEM is ignored. mem_rdata is ignored for stores.
- The counter is 8 bits. It clears on MEM entry and increments each MEM cycle without ack.

## Timing
- Bundle accepted at edge N (IDLE).
- Non-memory instruction: WB during cycle N+1 (rf_we, retire high). in_ready returns high at N+2. Throughput is one instruction per 2 cycles.
- Memory instruction: mem_req high from cycle N+1. If mem_ack arrives in cycle M (M>=N+1), mem_req is low at M+1, WB occurs in M+1, and in_ready is high at M+2.
- Timeout: with req starting at N+1 and no ack, req is last high in cycle N+TIMEOUT_CYCLES, and WB plus mem_err=1 occur in cycle N+TIMEOUT_CYCLES+1.
- mem_ack in the same cycle the counter hits its limit counts as success (ack has priority).
- rf_we, retire and pc_out are registered outputs: high for exactly one cycle, and 0 otherwise.
- rst in any state forces IDLE on that edge. mem_req, rf_we and retire are low from the next cycle, no write is issued, and a pending ack is discarded.

## Test plan
- ALU op: exe_out=0x0000_1234, rd=5, needs_wb=1 accepted at cycle 1 -> rf_we=1, waddr=5, wdata=0x1234, retire=1 in cycle 2; in_ready=1 in cycle 3.
- Load with 3-cycle wait: addr 0x100, ack with rdata=0xDEAD_BEEF on the 3rd req cycle -> mem_we=0 throughout, rf_wdata=0xDEADBEEF one cycle after ack, and mem_req low that cycle.
- Store: addr 0x204, store_data=0xA5A5_0001, needs_wb=1, immediate ack -> mem_we=1, mem_wdata=0xA5A50001, rf_we stays 0, retire pulses.
- Misaligned load to 0x102 -> no mem_req, mem_err=1, rf_we=0, retire one cycle after accept. mem_err stays 1 until rst.
- Timeout with TIMEOUT_CYCLES=4 and no ack -> mem_req high for exactly 4 cycles, then mem_err=1, rf_we=0. A later ALU op still writes normally.
- rd=0 with needs_wb=1 -> rf_we=0. rst asserted during MEM, then a late mem_ack -> no rf_we, and in_ready=1 the cycle after rst deasserts.
